// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one memory port between IF and LS, LS first.
// Optional response watchdog: define RV32_ARB_TIMEOUT_EN.
module rv32_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_W-1:0]     if_rdata,
   output logic                  if_err,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic [DATA_W/8-1:0]   ls_be,
   input  logic [ADDR_W-1:0]     ls_addr,
   input  logic [DATA_W-1:0]     ls_wdata,
   output logic                  ls_gnt,
   output logic                  ls_rvalid,
   output logic [DATA_W-1:0]     ls_rdata,
   output logic                  ls_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

   state_t            state;
   owner_t            owner;
   logic [3:0]        starve_cnt;
   logic              abort_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] ls_rdata_q;

   logic              pick_if;
   logic              pick_ls;
   logic              owner_req;
   logic              gnt_ok;
   logic              resp_ev;
   logic              rsp_live;
   logic              wd_fire;
   logic [DATA_W-1:0] rsp_data;

   always_comb begin
      pick_if = if_req & (~ls_req | (starve_cnt == 4'(STARVE_MAX)));
      pick_ls = ls_req & ~pick_if;
   end

   always_comb begin
      owner_req = 1'b0;
      case (owner)
         OWN_IF:  owner_req = if_req;
         OWN_LS:  owner_req = ls_req;
         default: owner_req = 1'b0;
      endcase
   end

   // an abandoned request still completes, but nothing is forwarded
   assign gnt_ok   = (state == REQ) & mem_gnt & owner_req & ~abort_q;
   assign resp_ev  = (state == RESP) & (mem_rvalid | wd_fire);
   assign rsp_live = resp_ev & ~abort_q;
   assign rsp_data = wd_fire ? '0 : mem_rdata;

   assign if_gnt    = gnt_ok & (owner == OWN_IF);
   assign ls_gnt    = gnt_ok & (owner == OWN_LS);
   assign if_rvalid = rsp_live & (owner == OWN_IF);
   assign ls_rvalid = rsp_live & (owner == OWN_LS);
   assign if_err    = if_rvalid & wd_fire;
   assign ls_err    = ls_rvalid & wd_fire;
   assign if_rdata  = if_rvalid ? rsp_data : if_rdata_q;
   assign ls_rdata  = ls_rvalid ? rsp_data : ls_rdata_q;

`ifdef RV32_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_cnt;

   assign wd_fire = (state == RESP) && (wd_cnt == WD_W'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (state != RESP || wd_fire) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end
   end
`else
   logic unused_timeout;

   assign wd_fire        = 1'b0;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= OWN_NONE;
         starve_cnt <= 4'd0;
         abort_q    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         if (if_rvalid) if_rdata_q <= rsp_data;
         if (ls_rvalid) ls_rdata_q <= rsp_data;
         case (state)
            IDLE: begin
               if (pick_if | pick_ls) begin
                  state     <= REQ;
                  mem_req   <= 1'b1;
                  abort_q   <= 1'b0;
                  owner     <= pick_if ? OWN_IF : OWN_LS;
                  mem_we    <= pick_ls & ls_we;
                  mem_be    <= pick_ls ? ls_be : '1;
                  mem_addr  <= pick_ls ? ls_addr : if_addr;
                  mem_wdata <= pick_ls ? ls_wdata : '0;
                  if (pick_if) begin
                     starve_cnt <= 4'd0;
                  end else if (if_req &&
                               starve_cnt != 4'(STARVE_MAX)) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
               end
            end
            REQ: begin
               abort_q <= abort_q | ~owner_req;
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= RESP;
               end
            end
            RESP: begin
               if (resp_ev) begin
                  state <= IDLE;
                  owner <= OWN_NONE;
               end
            end
            default: begin
               state <= IDLE;
               owner <= OWN_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: scoreboard bench for the IF/LS memory arbiter.
// Memory model answers on the falling edge; checks sample 2 ns later.
module tb_rv32_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [3:0]  ls_be = '0;
   logic [31:0] ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic        ls_gnt, ls_rvalid, ls_err;
   logic [31:0] ls_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   typedef struct {
      logic        is_ls;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   int          gnt_dly = 0;
   int          rsp_dly = 0;
   int          m_cnt = 0;
   int          m_done = 0;
   bit          never = 0;
   bit          spur = 0;
   bit          m_busy = 0;
   logic [31:0] m_addr = '0;
   logic        m_we = 1'b0;

   always #5 clk = ~clk;

   rv32_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
      .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   // reads return addr+3, writes acknowledge with zero data
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
         m_busy = 0; m_cnt = 0;
      end else begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (!m_busy) begin
            if (mem_req) begin
               if (m_cnt >= gnt_dly) begin
                  mem_gnt = 1'b1; m_busy = 1; m_cnt = 0;
                  m_addr = mem_addr; m_we = mem_we;
               end else m_cnt++;
            end else if (spur) begin
               mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            end
         end else if (!never) begin
            if (m_cnt >= rsp_dly) begin
               mem_rvalid = 1'b1;
               mem_rdata = m_we ? 32'h0 : m_addr + 32'h3;
               m_busy = 0; m_cnt = 0; m_done++;
            end else m_cnt++;
         end
      end
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #2;
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           if_gnt, if_rvalid, if_err, if_rdata,
           ls_gnt, ls_rvalid, ls_err, ls_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: mem_req=%b addr=%h be=%h rd=%h/%h, want 0",
                  mem_req, mem_addr, mem_be, if_rdata, ls_rdata);
      end
      @(negedge clk); rst_n = 1'b1;
      gnt_dly = 100;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h80;
      ls_req = 1'b1; ls_addr = 32'h90; ls_be = 4'hF;
      for (int w = 0; w < 5; w++) begin
         @(negedge clk); #2;
         if (mem_req) break;
      end
      checks++;
      if (mem_req !== 1'b1 || dut.starve_cnt !== 4'd1) begin
         errors++;
         $display("FAIL midreq_setup: mem_req=%b starve=%0d, want 1/1",
                  mem_req, dut.starve_cnt);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || if_gnt !== 1'b0 || ls_gnt !== 1'b0 ||
          mem_addr !== '0 || dut.starve_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_async: req=%b gnt=%b%b addr=%h starve=%0d, want 0",
                  mem_req, if_gnt, ls_gnt, mem_addr, dut.starve_cnt);
      end
      #13;
      if_req = 1'b0; ls_req = 1'b0; gnt_dly = 0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      checks++;
      if (mem_req !== 1'b0 || if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: mem_req=%b rvalid=%b%b, want 0",
                  mem_req, if_rvalid, ls_rvalid);
      end
   endtask

   task automatic test_if_read();
      int gcnt, rcnt, gat, rat;
      bit lsact;
      logic [31:0] g_addr;
      logic g_we;
      logic [3:0] g_be;
      exp_t e;
      gcnt = 0; rcnt = 0; gat = -1; rat = -1; lsact = 0;
      g_addr = '0; g_we = 1'b1; g_be = '0;
      gnt_dly = 0; rsp_dly = 1;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0000_0010;
      exp_q.push_back('{1'b0, 32'h0000_0013});
      for (int c = 0; c < 8; c++) begin
         #2;
         if (ls_gnt | ls_rvalid | ls_err) lsact = 1;
         if (if_gnt) begin
            gcnt++; gat = c;
            g_addr = mem_addr; g_we = mem_we; g_be = mem_be;
         end
         if (if_rvalid) begin
            rcnt++; rat = c;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL if_read_data: unexpected rvalid rdata=%h", if_rdata);
            end else begin
               e = exp_q.pop_front();
               if (e.is_ls !== 1'b0 || if_rdata !== e.data || if_err !== 1'b0) begin
                  errors++;
                  $display("FAIL if_read_data: got %h err=%b, want %h err=0",
                           if_rdata, if_err, e.data);
               end
            end
         end
         @(negedge clk);
         if (gat == c) if_req = 1'b0;
      end
      checks++;
      if (gcnt != 1 || gat != 1) begin
         errors++;
         $display("FAIL if_read_gnt: %0d pulses at cycle %0d, want 1 at 1", gcnt, gat);
      end
      checks++;
      if (rcnt != 1 || rat != 3) begin
         errors++;
         $display("FAIL if_read_rvalid: %0d pulses at cycle %0d, want 1 at 3", rcnt, rat);
      end
      checks++;
      if (g_addr !== 32'h10 || g_we !== 1'b0 || g_be !== 4'hF) begin
         errors++;
         $display("FAIL if_read_mem: addr=%h we=%b be=%h, want 00000010 0 f",
                  g_addr, g_we, g_be);
      end
      checks++;
      if (lsact) begin
         errors++;
         $display("FAIL if_read_ls_quiet: ls activity seen, want none");
      end
      #2;
      checks++;
      if (if_rvalid !== 1'b0 || if_rdata !== 32'h13) begin
         errors++;
         $display("FAIL if_read_hold: rvalid=%b rdata=%h, want 0 00000013",
                  if_rvalid, if_rdata);
      end
   endtask

   task automatic test_starvation();
      logic ord_q[$];
      int ng, last;
      bit cad_bad, who, gnt_now;
      exp_t e;
      ord_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      ng = 0; last = -1; cad_bad = 0;
      gnt_dly = 0; rsp_dly = 0;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h200;
      for (int c = 0; c < 60; c++) begin
         #2;
         gnt_now = if_gnt | ls_gnt;
         who = ls_gnt;
         if (gnt_now) begin
            checks++;
            if (ord_q.size() == 0 || (if_gnt & ls_gnt) || who !== ord_q[0]) begin
               errors++;
               $display("FAIL starve_order: grant %0d ls=%b if=%b, want ls=%b",
                        ng, ls_gnt, if_gnt, ord_q.size() > 0 ? ord_q[0] : 1'bx);
            end
            if (ord_q.size() > 0) void'(ord_q.pop_front());
            exp_q.push_back('{who, (who ? ls_addr : if_addr) + 32'h3});
            if (last >= 0 && c - last != 3) cad_bad = 1;
            last = c; ng++;
            if (ng == 4) begin
               checks++;
               if (dut.starve_cnt !== 4'd4) begin
                  errors++;
                  $display("FAIL starve_cnt_max: got %0d, want 4", dut.starve_cnt);
               end
            end
            if (ng == 5) begin
               checks++;
               if (dut.starve_cnt !== 4'd0) begin
                  errors++;
                  $display("FAIL starve_cnt_clear: got %0d, want 0", dut.starve_cnt);
               end
            end
         end
         if (if_rvalid | ls_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL starve_data: unexpected rvalid if=%b ls=%b", if_rvalid, ls_rvalid);
            end else begin
               e = exp_q.pop_front();
               if ((if_rvalid & ls_rvalid) || e.is_ls !== ls_rvalid ||
                   (ls_rvalid ? ls_rdata : if_rdata) !== e.data) begin
                  errors++;
                  $display("FAIL starve_data: ls=%b rdata=%h/%h, want ls=%b %h",
                           ls_rvalid, if_rdata, ls_rdata, e.is_ls, e.data);
               end
            end
         end
         if (ng == 6 && exp_q.size() == 0) break;
         @(negedge clk);
         if (gnt_now && who) ls_addr = ls_addr + 32'h4;
         if (ng == 6) begin if_req = 1'b0; ls_req = 1'b0; end
      end
      if_req = 1'b0; ls_req = 1'b0;
      checks++;
      if (ng != 6 || exp_q.size() != 0 || cad_bad) begin
         errors++;
         $display("FAIL starve_done: grants=%0d pending=%0d cadence_bad=%b, want 6 0 0",
                  ng, exp_q.size(), cad_bad);
      end
   endtask

   task automatic test_ls_write();
      int reqcyc, rv;
      bit bad, ifact, g;
      logic errv;
      exp_t e;
      reqcyc = 0; rv = 0; bad = 0; ifact = 0; errv = 1'bx;
      gnt_dly = 3; rsp_dly = 0;
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0010;
      ls_addr = 32'h1000_0000; ls_wdata = 32'h0000_AB00;
      exp_q.push_back('{1'b1, 32'h0});
      for (int c = 0; c < 20; c++) begin
         #2;
         g = ls_gnt;
         if (if_gnt | if_rvalid) ifact = 1;
         if (mem_req) begin
            reqcyc++;
            if (mem_we !== 1'b1 || mem_be !== 4'b0010 ||
                mem_addr !== 32'h1000_0000 || mem_wdata !== 32'h0000_AB00)
               bad = 1;
         end
         if (ls_rvalid) begin
            rv++; errv = ls_err;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ls_write_ack: unexpected rvalid");
            end else begin
               e = exp_q.pop_front();
               if (e.is_ls !== 1'b1 || ls_rdata !== e.data) begin
                  errors++;
                  $display("FAIL ls_write_ack: rdata=%h, want %h", ls_rdata, e.data);
               end
            end
         end
         @(negedge clk);
         if (g) begin ls_req = 1'b0; ls_we = 1'b0; end
      end
      checks++;
      if (bad || reqcyc != 4) begin
         errors++;
         $display("FAIL ls_write_mem: bad=%b req_cycles=%0d, want 0 4", bad, reqcyc);
      end
      checks++;
      if (rv != 1 || errv !== 1'b0 || ifact) begin
         errors++;
         $display("FAIL ls_write_resp: rvalids=%0d err=%b if_act=%b, want 1 0 0",
                  rv, errv, ifact);
      end
   endtask

   task automatic test_stall();
      int stall;
      bit bad, got, g;
      exp_t e;
      stall = 0; bad = 0; got = 0;
      gnt_dly = 10; rsp_dly = 0;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h44;
      exp_q.push_back('{1'b0, 32'h47});
      for (int c = 0; c < 30; c++) begin
         #2;
         g = if_gnt;
         if (mem_req && !mem_gnt) begin
            stall++;
            if (mem_addr !== 32'h44 || if_gnt || ls_gnt) bad = 1;
         end
         if (if_rvalid | ls_rvalid) begin
            got = 1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stall_data: unexpected rvalid");
            end else begin
               e = exp_q.pop_front();
               if (e.is_ls !== ls_rvalid || if_rdata !== e.data) begin
                  errors++;
                  $display("FAIL stall_data: rdata=%h, want %h", if_rdata, e.data);
               end
            end
         end
         if (got) break;
         @(negedge clk);
         if (g) if_req = 1'b0;
      end
      if_req = 1'b0;
      checks++;
      if (stall != 10 || bad) begin
         errors++;
         $display("FAIL stall_hold: stall_cycles=%0d bad=%b, want 10 0", stall, bad);
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL stall_timeout: no response, want one");
      end
   endtask

   task automatic test_abandon();
      int done0;
      bit act, sp, got, g;
      exp_t e;
      act = 0; sp = 0; got = 0;
      done0 = m_done;
      gnt_dly = 3; rsp_dly = 0;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h300;
      for (int c = 0; c < 12; c++) begin
         #2;
         if (if_gnt | if_rvalid | ls_gnt | ls_rvalid) act = 1;
         @(negedge clk);
         if (c == 1) if_req = 1'b0;
      end
      checks++;
      if (act || m_done != done0 + 1) begin
         errors++;
         $display("FAIL abandon: activity=%b mem_done=%0d, want 0 %0d",
                  act, m_done - done0, 1);
      end
      #2 spur = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #2;
         if (if_rvalid | ls_rvalid) sp = 1;
      end
      spur = 0; gnt_dly = 0;
      checks++;
      if (sp) begin
         errors++;
         $display("FAIL idle_rvalid: rvalid forwarded, want ignored");
      end
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h400;
      exp_q.push_back('{1'b1, 32'h403});
      for (int c = 0; c < 10; c++) begin
         #2;
         g = ls_gnt;
         if (if_rvalid | ls_rvalid) begin
            got = 1;
            checks++;
            e = exp_q.pop_front();
            if (e.is_ls !== ls_rvalid || ls_rdata !== e.data) begin
               errors++;
               $display("FAIL after_abandon: rdata=%h, want %h", ls_rdata, e.data);
            end
         end
         if (got) break;
         @(negedge clk);
         if (g) ls_req = 1'b0;
      end
      ls_req = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL after_abandon_timeout: no response, want one");
      end
   endtask

`ifdef RV32_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int gat, rat;
      bit g, late, got;
      exp_t e;
      gat = -1; rat = -1; late = 0; got = 0;
      gnt_dly = 0; rsp_dly = 0; never = 1;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h500;
      exp_q.push_back('{1'b0, 32'h0});
      for (int c = 0; c < 20; c++) begin
         #2;
         g = if_gnt;
         if (g) gat = c;
         if (if_rvalid) begin
            rat = c;
            checks++;
            e = exp_q.pop_front();
            if (if_err !== 1'b1 || if_rdata !== e.data) begin
               errors++;
               $display("FAIL timeout_resp: err=%b rdata=%h, want 1 %h",
                        if_err, if_rdata, e.data);
            end
         end
         if (rat >= 0) break;
         @(negedge clk);
         if (g) if_req = 1'b0;
      end
      if_req = 1'b0;
      checks++;
      if (gat < 0 || rat - gat != 9) begin
         errors++;
         $display("FAIL timeout_cycle: gnt=%0d rvalid=%0d, want rvalid 9 after gnt",
                  gat, rat);
      end
      never = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #2;
         if (if_rvalid | ls_rvalid) late = 1;
      end
      checks++;
      if (late) begin
         errors++;
         $display("FAIL timeout_late: late rvalid forwarded, want ignored");
      end
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h600;
      exp_q.push_back('{1'b1, 32'h603});
      for (int c = 0; c < 10; c++) begin
         #2;
         g = ls_gnt;
         if (ls_rvalid) begin
            got = 1;
            checks++;
            e = exp_q.pop_front();
            if (ls_rdata !== e.data || ls_err !== 1'b0) begin
               errors++;
               $display("FAIL timeout_next: rdata=%h err=%b, want %h 0",
                        ls_rdata, ls_err, e.data);
            end
         end
         if (got) break;
         @(negedge clk);
         if (g) ls_req = 1'b0;
      end
      ls_req = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL timeout_next_missing: no response, want one");
      end
   endtask
`endif

   initial begin
      test_reset();
      test_if_read();
      test_starvation();
      test_ls_write();
      test_stall();
      test_abandon();
`ifdef RV32_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
